sprite_rom_arbiter: RTL and testbench

Shares one single-port, fixed-latency sprite ROM/RAM read port between several pixel-pipeline requesters: the Pac-Man, red-ghost, item and spare sprite fetchers. Arbitration is round-robin. Each requester has a valid/ready request channel and a one-deep response buffer. The block sits between the per-sprite address generators and a single shared sprite memory, so the sprite banks can be merged into one memory.

---
 rtl/sprite_arb_pkg.sv | 22 ++
 rtl/sprite_rom_arbiter_rr.sv | 48 ++++
 rtl/sprite_rom_arbiter.sv | 119 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite memory read-port arbiter.
// The tag index is sized for up to four requesters.
package sprite_arb_pkg;

  localparam int REQ_PACMAN   = 0;
  localparam int REQ_REDGHOST = 1;
  localparam int REQ_ITEMS    = 2;
  localparam int REQ_SPARE    = 3;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 24;
  localparam int MEM_LAT_DEF = 1;

  localparam int IDX_W = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin arbiter: searches from last_grant+1, wrapping modulo N.
// The pointer moves only when a grant is issued and advance is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_eligible,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_gnt_idx;
  logic [IW-1:0] w_cand;
  logic          w_any;
  int            w_sum;

  always_comb begin
    o_grant   = '0;
    w_gnt_idx = r_last;
    w_cand    = '0;
    w_any     = 1'b0;
    w_sum     = 0;
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(r_last) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = IW'(w_sum);
      if (!w_any && i_eligible[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        w_gnt_idx       = w_cand;
        w_any           = 1'b1;
      end
    end
  end

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= IW'(N - 1);
    end else if (i_advance && w_any) begin
      r_last <= w_gnt_idx;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one fixed-latency sprite memory read port between up to four
// requesters with round-robin grants and a one-deep response buffer each.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*DATA_W-1:0]   rsp_data,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data
);

  // Handshake: a request moves when req_valid[i] & req_ready[i]; a response
  // moves when rsp_valid[i] & rsp_ready[i]. req_ready is at most one-hot.

  logic [N_REQ-1:0]  w_eligible;
  logic [N_REQ-1:0]  w_grant;
  logic [N_REQ-1:0]  w_fill;
  logic [N_REQ-1:0]  r_inflight;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data [N_REQ];
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [ADDR_W-1:0] w_addr;
  tag_t              r_tag [MEM_LAT];
  tag_t              w_tag_in;
  tag_t              w_tag_out;

  // A buffer being drained this cycle can accept the next read.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_eligible[i] = req_valid[i] && !r_inflight[i] &&
                      (!r_rsp_valid[i] || rsp_ready[i]);
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_eligible (w_eligible),
    .i_advance  (!Reset),
    .o_grant    (w_grant)
  );

  assign req_ready = w_grant & {N_REQ{!Reset}};

  always_comb begin
    w_gnt_idx = '0;
    w_addr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        w_gnt_idx = IDX_W'(i);
        w_addr    = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign mem_rd   = |req_ready;
  assign mem_addr = w_addr;

  assign w_tag_in  = '{valid: mem_rd, idx: w_gnt_idx};
  assign w_tag_out = r_tag[MEM_LAT-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < MEM_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < MEM_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_fill[i] = w_tag_out.valid && (w_tag_out.idx == IDX_W'(i));
    end
  end

  // Clearing the tag pipe on reset is what discards pre-reset read data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_inflight  <= '0;
      r_rsp_valid <= '0;
      for (int i = 0; i < N_REQ; i++) r_rsp_data[i] <= '0;
    end else begin
      r_inflight <= (r_inflight & ~w_fill) | req_ready;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_fill[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= mem_data;
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_data[i*DATA_W +: DATA_W] = r_rsp_data[i];
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: MEM_LAT=1 main instance with a
// response scoreboard, plus a MEM_LAT=3 instance for the latency check.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 24;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;

  logic [N-1:0]    d3_req_valid;
  logic [N*AW-1:0] d3_req_addr;
  logic [N-1:0]    d3_req_ready;
  logic [N-1:0]    d3_rsp_valid;
  logic [N*DW-1:0] d3_rsp_data;
  logic [N-1:0]    d3_rsp_ready;
  logic            d3_mem_rd;
  logic [AW-1:0]   d3_mem_addr;
  logic [DW-1:0]   d3_mem_data;

  int total = 0;
  int bad   = 0;

  // Entries are {requester index, expected pixel}.
  logic [DW+1:0] exp_q[$];

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .Clk(clk), .Reset(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
    .Clk(clk), .Reset(rst),
    .req_valid(d3_req_valid), .req_addr(d3_req_addr), .req_ready(d3_req_ready),
    .rsp_valid(d3_rsp_valid), .rsp_data(d3_rsp_data), .rsp_ready(d3_rsp_ready),
    .mem_rd(d3_mem_rd), .mem_addr(d3_mem_addr), .mem_data(d3_mem_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // memory models
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 12'h0A5) return 24'h47B7AE;
    return {12'h000, a};
  endfunction

  logic [AW-1:0] m1_a;
  logic [AW-1:0] m3_a [3];

  always @(posedge clk) begin
    m1_a    <= mem_addr;
    m3_a[0] <= d3_mem_addr;
    m3_a[1] <= m3_a[0];
    m3_a[2] <= m3_a[1];
  end

  assign mem_data    = mem_f(m1_a);
  assign d3_mem_data = mem_f(m3_a[2]);

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard: push on request acceptance, pop on response consumption
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          int hit;
          hit = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (hit < 0 && exp_q[j][DW+1:DW] == 2'(i)) hit = j;
          end
          if (hit < 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected req=%0d act=%0h exp=none", i, rsp_data[i*DW +: DW]);
          end else begin
            chk($sformatf("rsp_data%0d", i), 32'(rsp_data[i*DW +: DW]), 32'(exp_q[hit][DW-1:0]));
            exp_q.delete(hit);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({2'(i), mem_f(req_addr[i*AW +: AW])});
        end
      end
    end
  end

  int rr_exp [8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
  int bp_exp [10] = '{1, 2, 3, 0, 1, 3, 0, 1, 3, 0};

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_addr     = '0;
    rsp_ready    = '0;
    d3_req_valid = '0;
    d3_req_addr  = '0;
    d3_rsp_ready = '0;

    // reset state, with requests pending
    repeat (2) step();
    req_valid = 4'hF;
    at_neg();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data[31:0]), 32'h0);
    step();
    rst       = 1'b0;
    req_valid = '0;
    repeat (2) step();

    // single request
    set_addr(0, 12'h0A5);
    req_valid = 4'b0001;
    rsp_ready = 4'hF;
    at_neg();
    chk("single_grant", 32'(req_ready), 32'h1);
    chk("single_mem_rd", 32'(mem_rd), 32'h1);
    chk("single_mem_addr", 32'(mem_addr), 32'h0A5);
    step();
    at_neg();
    chk("single_inflight_block", 32'(req_ready), 32'h0);
    chk("single_rsp_early", 32'(rsp_valid[0]), 32'h0);
    step();
    at_neg();
    chk("single_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    chk("single_rsp_data", 32'(rsp_data[DW-1:0]), 32'h47B7AE);
    chk("single_regrant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) step();

    // round-robin with all requesters active and addresses moving
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_addr(i, AW'(12'h100 * (i + 1) + k));
      req_valid = 4'hF;
      at_neg();
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << rr_exp[k]));
      chk($sformatf("rr_mem_rd%0d", k), 32'(mem_rd), 32'h1);
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // backpressure on requester 2
    for (int i = 0; i < N; i++) set_addr(i, AW'(12'h500 + i));
    rsp_ready = 4'b1011;
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      at_neg();
      chk($sformatf("bp_grant%0d", k), 32'(req_ready), 32'(1 << bp_exp[k]));
      if (k >= 3) begin
        chk($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid[2]), 32'h1);
        chk($sformatf("bp_hold_data%0d", k), 32'(rsp_data[2*DW +: DW]), 32'h000502);
      end
      step();
    end
    req_valid = 4'b0100;
    rsp_ready = 4'hF;
    at_neg();
    chk("bp_release_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    repeat (3) step();

    // simultaneous drain and grant on requester 1
    set_addr(1, 12'h0B1);
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    at_neg();
    chk("dg_first_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (3) step();
    set_addr(1, 12'h0B2);
    req_valid = 4'b0010;
    rsp_ready = 4'hF;
    at_neg();
    chk("dg_full", 32'(rsp_valid[1]), 32'h1);
    chk("dg_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    at_neg();
    chk("dg_drained", 32'(rsp_valid[1]), 32'h0);
    step();
    at_neg();
    chk("dg_new_valid", 32'(rsp_valid[1]), 32'h1);
    chk("dg_new_data", 32'(rsp_data[DW +: DW]), 32'h0000B2);
    step();
    repeat (3) step();

    // reset in the cycle after a grant to requester 3
    set_addr(3, 12'h0C3);
    req_valid = 4'b1000;
    at_neg();
    chk("mr_grant3", 32'(req_ready), 32'h8);
    step();
    rst       = 1'b1;
    req_valid = '0;
    at_neg();
    chk("mr_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    at_neg();
    chk("mr_rsp_clear", 32'(rsp_valid), 32'h0);
    step();
    at_neg();
    chk("mr_stale_discard", 32'(rsp_valid), 32'h0);
    step();
    for (int i = 0; i < N; i++) set_addr(i, AW'(12'h700 + i));
    req_valid = 4'hF;
    at_neg();
    chk("mr_first_grant", 32'(req_ready), 32'h1);
    step();
    at_neg();
    chk("mr_second_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (4) step();

    // MEM_LAT=3 instance: single request, response at T+4
    d3_req_addr[AW-1:0] = 12'h0A5;
    d3_req_valid        = 4'b0001;
    d3_rsp_ready        = 4'hF;
    at_neg();
    chk("lat3_grant", 32'(d3_req_ready), 32'h1);
    chk("lat3_mem_rd", 32'(d3_mem_rd), 32'h1);
    step();
    d3_req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      at_neg();
      chk($sformatf("lat3_wait%0d", k), 32'(d3_rsp_valid[0]), 32'h0);
      step();
    end
    at_neg();
    chk("lat3_rsp_valid", 32'(d3_rsp_valid[0]), 32'h1);
    chk("lat3_rsp_data", 32'(d3_rsp_data[DW-1:0]), 32'h47B7AE);
    step();
    repeat (3) step();

    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
